fifo_wr_ctrl: RTL

Next-generation write-side controller for the gray-pointer FIFO family. It generates the memory write address and the gray-coded write pointer. It adds:
- gated writes (a write while full is dropped),
- a registered fill level,
- a programmable almost-full flag,
- an overflow error flag, selectable as sticky or pulsed.

It sits in the write clock domain, beside the dual-port RAM. Its read-pointer input is already synchronised into this domain.

---
 rtl/fifo_pkg.sv | 41 ++++
 rtl/fifo_wr_ctrl_if.sv | 65 ++++++
 rtl/fifo_wr_ctrl.sv | 88 ++++++++
 3 files changed

// File: rtl/fifo_pkg.sv
// ---------------------------------------------------------------------------
// fifo_pkg
// Shared definitions for the gray-pointer FIFO family. The read-side and
// write-side controllers both import this package so that their pointer
// conversions are bit-identical.
//
// Contents:
//   PTR_W_MAX  widest pointer the conversion helpers handle
//   ptr_max_t  pointer container type used by the helpers
//   depth_of   FIFO depth from address width (2**AW)
//   bin2gray   binary to reflected gray
//   gray2bin   reflected gray to binary (XOR prefix from the MSB)
//
// The helpers work on a fixed-width container. Callers zero-extend their
// AW+1 bit pointer into it and truncate the result. Zero upper bits do not
// change either conversion, so any pointer up to PTR_W_MAX bits is exact.
// ---------------------------------------------------------------------------
package fifo_pkg;

  localparam int PTR_W_MAX = 16;

  typedef logic [PTR_W_MAX-1:0] ptr_max_t;

  function automatic int depth_of(input int aw);
    return 1 << aw;
  endfunction

  function automatic ptr_max_t bin2gray(input ptr_max_t bin);
    return bin ^ (bin >> 1);
  endfunction

  function automatic ptr_max_t gray2bin(input ptr_max_t gray);
    ptr_max_t bin;
    bin[PTR_W_MAX-1] = gray[PTR_W_MAX-1];
    for (int i = PTR_W_MAX - 2; i >= 0; i--) begin
      bin[i] = bin[i+1] ^ gray[i];
    end
    return bin;
  endfunction

endpackage

// File: rtl/fifo_wr_ctrl_if.sv
// ---------------------------------------------------------------------------
// fifo_wr_ctrl_if
// Request and status bundle between the write-side FIFO controller and the
// logic that uses it. The clock and reset stay as plain ports on the
// controller.
//
// Signals:
//   I_WR_EN      write request
//   I_WR_RD_PTR  gray read pointer, already synchronised to the write clock
//   I_AFULL_TH   almost-full threshold in words (0..DEPTH), quasi-static
//   I_OVF_CLR    clears a sticky overflow flag
//   O_WR_ADDR    binary RAM write address
//   O_WR_PTR     gray write pointer (goes to the read-side synchroniser)
//   O_WR_FULL    FIFO full
//   O_WR_AFULL   level >= threshold
//   O_WR_LEVEL   fill level, 0..DEPTH
//   O_WR_OVF     overflow: a write was attempted while full
//
// Modports:
//   master  the user side; drives requests and reads status
//   slave   the controller
// ---------------------------------------------------------------------------
interface fifo_wr_ctrl_if #(
  parameter int AW = 4
);

  logic          I_WR_EN;
  logic [AW:0]   I_WR_RD_PTR;
  logic [AW:0]   I_AFULL_TH;
  logic          I_OVF_CLR;

  logic [AW-1:0] O_WR_ADDR;
  logic [AW:0]   O_WR_PTR;
  logic          O_WR_FULL;
  logic          O_WR_AFULL;
  logic [AW:0]   O_WR_LEVEL;
  logic          O_WR_OVF;

  modport master (
    output I_WR_EN,
    output I_WR_RD_PTR,
    output I_AFULL_TH,
    output I_OVF_CLR,
    input  O_WR_ADDR,
    input  O_WR_PTR,
    input  O_WR_FULL,
    input  O_WR_AFULL,
    input  O_WR_LEVEL,
    input  O_WR_OVF
  );

  modport slave (
    input  I_WR_EN,
    input  I_WR_RD_PTR,
    input  I_AFULL_TH,
    input  I_OVF_CLR,
    output O_WR_ADDR,
    output O_WR_PTR,
    output O_WR_FULL,
    output O_WR_AFULL,
    output O_WR_LEVEL,
    output O_WR_OVF
  );

endinterface

// File: rtl/fifo_wr_ctrl.sv
// ---------------------------------------------------------------------------
// fifo_wr_ctrl
// Write-side controller for the gray-pointer FIFO. It lives in the write
// clock domain next to the dual-port RAM. It produces the RAM write address,
// the gray write pointer for the read side, and a registered fill level with
// full, almost-full and overflow flags.
//
// Ports:
//   I_WR_CLK  write clock, all logic on the rising edge
//   I_WR_RST  synchronous active-high reset
//   wr_if     fifo_wr_ctrl_if.slave (requests in, status out)
//
// Parameters:
//   AW          address width, depth = 2**AW
//   OVF_STICKY  1: overflow holds until I_OVF_CLR; 0: one pulse per drop
// ---------------------------------------------------------------------------
module fifo_wr_ctrl
  import fifo_pkg::*;
#(
  parameter int AW         = 4,
  parameter bit OVF_STICKY = 1'b1
) (
  input  logic             I_WR_CLK,
  input  logic             I_WR_RST,
  fifo_wr_ctrl_if.slave    wr_if
);

  localparam int PW    = AW + 1;
  localparam int DEPTH = depth_of(AW);

  logic [PW-1:0] wr_bin;
  logic [PW-1:0] wr_gray;
  logic [PW-1:0] wr_bin_next;
  logic [PW-1:0] rd_bin;
  logic [PW-1:0] lvl_next;
  logic [PW-1:0] level_q;
  logic          full_q;
  logic          afull_q;
  logic          ovf_q;
  logic          push;
  logic          ovf_evt;

  // Gating uses the registered full flag. A write that arrives in the same
  // cycle as a read-pointer advance is still dropped. The flag runs one
  // cycle pessimistic, but the comparison stays off the combinational path.
  assign push    = wr_if.I_WR_EN & ~full_q;
  assign ovf_evt = wr_if.I_WR_EN &  full_q;

  assign wr_bin_next = wr_bin + PW'(push);

  assign rd_bin   = PW'(gray2bin(ptr_max_t'(wr_if.I_WR_RD_PTR)));

  // The modulo-2**PW difference is in 0..DEPTH whenever the read pointer is
  // legal. The extra pointer bit tells full (DEPTH) apart from empty (0).
  assign lvl_next = wr_bin_next - rd_bin;

  always_ff @(posedge I_WR_CLK) begin
    if (I_WR_RST) begin
      wr_bin  <= '0;
      wr_gray <= '0;
      level_q <= '0;
      full_q  <= 1'b0;
      afull_q <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      wr_bin  <= wr_bin_next;
      wr_gray <= PW'(bin2gray(ptr_max_t'(wr_bin_next)));
      level_q <= lvl_next;
      full_q  <= (lvl_next == PW'(DEPTH));
      afull_q <= (lvl_next >= wr_if.I_AFULL_TH);
      if (OVF_STICKY) begin
        // If a drop and a clear arrive in the same cycle, the drop wins, so
        // no overflow is lost.
        ovf_q <= ovf_evt | (ovf_q & ~wr_if.I_OVF_CLR);
      end else begin
        ovf_q <= ovf_evt;
      end
    end
  end

  assign wr_if.O_WR_ADDR  = wr_bin[AW-1:0];
  assign wr_if.O_WR_PTR   = wr_gray;
  assign wr_if.O_WR_FULL  = full_q;
  assign wr_if.O_WR_AFULL = afull_q;
  assign wr_if.O_WR_LEVEL = level_q;
  assign wr_if.O_WR_OVF   = ovf_q;

endmodule
